// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// The FSM encoding is kept as plain localparams so existing code can reuse it.
package seg7_scan_ctrl_pkg;

  localparam logic SHOW  = 1'b0;
  localparam logic BLANK = 1'b1;

  typedef logic [6:0] seg_t;

  // Active-low cathodes {g,f,e,d,c,b,a}: all segments off.
  localparam seg_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg7_scan_ctrl_seg7.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational; the scan controller registers its output.
module seg7_scan_ctrl_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// New values wait in a shadow register and are committed only at a frame boundary.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic                    ready,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic          state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] disp;
  logic [DW-1:0] shadow;
  logic          pending;
  logic [3:0]    nib;
  logic          suppress;
  seg_t          dec_seg;

  // Handshake: ready is high exactly while the shadow register is empty;
  // a transfer happens on any edge where load && ready.
  assign ready = !pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SHOW;
      idx        <= '0;
      cnt        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (load && !pending) begin
        shadow  <= value;
        pending <= 1'b1;
      end
      case (state)
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt   <= '0;
            state <= BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= SHOW;
            // Explicit wrap compare keeps non-power-of-2 digit counts in range.
            if (idx == IDX_LAST) begin
              idx        <= '0;
              frame_tick <= 1'b1;
              if (pending) begin
                disp    <= shadow;
                pending <= 1'b0;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Select the current digit and decide whether it is a suppressed leading zero.
  always_comb begin
    nib      = disp[3:0];
    suppress = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib      = disp[4*i +: 4];
        suppress = lz_en && ((disp >> (4 * i)) == '0);
      end
    end
  end

  seg7_scan_ctrl_seg7 u_seg7 (
    .digit (nib),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_OFF;
    end else if (state == SHOW && !suppress) begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= dec_seg;
    end else begin
      an  <= '1;
      seg <= SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with a 24-cycle frame (4 digits x (4 lit + 2 blank)).
// Stimulus pushes the expected {an,seg,ready,frame_tick} per cycle; a monitor compares.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int RDIV  = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = RDIV + BLK;
  localparam int FRAME = ND * SLOT;
  localparam int EW    = ND + 7 + 1 + 1;

  logic          clk;
  logic          reset;
  logic [15:0]   value;
  logic          load;
  logic          ready;
  logic          lz_en;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          frame_tick;

  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];

  int            n_checks;
  int            n_fail;
  int            cyc;
  logic [15:0]   m_disp;
  logic [15:0]   m_shadow;
  logic          m_pending;

  logic [6:0] hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .ready      (ready),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs c edges after reset release; outputs trail the FSM by one cycle.
  function automatic logic [EW-1:0] exp_out(int c, logic [15:0] d_old, logic lz, logic pend);
    logic [ND-1:0] a;
    logic [6:0]    s;
    int            q;
    int            dg;
    int            r;
    a = '1;
    s = 7'h7F;
    if (c > 0) begin
      q  = (c - 1) % FRAME;
      dg = q / SLOT;
      r  = q % SLOT;
      if (r < RDIV && !(lz && dg > 0 && (d_old >> (4 * dg)) == 16'h0)) begin
        a = ~(4'b0001 << dg);
        s = hex_seg[d_old[4*dg +: 4]];
      end
    end
    return {a, s, !pend, (c > 0 && (c % FRAME) == 0)};
  endfunction

  // driver tasks
  task automatic push_exp(logic [EW-1:0] e);
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
  endtask

  task automatic model_reset();
    cyc       = 0;
    m_disp    = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
    push_exp(exp_out(0, m_disp, lz_en, m_pending));
  endtask

  // One clock edge with the currently driven inputs; returns at posedge+1.
  task automatic tick();
    logic [15:0] d_old;
    logic        old_p;
    @(posedge clk);
    #1;
    d_old = m_disp;
    old_p = m_pending;
    if (((cyc + 1) % FRAME) == 0 && old_p) begin
      m_disp    = m_shadow;
      m_pending = 1'b0;
    end
    if (load && !old_p) begin
      m_shadow  = value;
      m_pending = 1'b1;
    end
    cyc++;
    push_exp(exp_out(cyc, d_old, lz_en, m_pending));
  endtask

  task automatic run_to(int target);
    while (cyc < target) tick();
  endtask

  task automatic async_reset_check();
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    #1;
    exp_q.delete();
    cyc_q.delete();
    reset = 1'b1;
    #1;
    got  = {an, seg, ready, frame_tick};
    want = {4'b1111, 7'h7F, 1'b1, 1'b0};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_reset: got an=%b seg=%b ready=%b ft=%b, expected an=%b seg=%b ready=%b ft=%b",
               got[12:9], got[8:2], got[1], got[0], want[12:9], want[8:2], want[1], want[0]);
    end
    lz_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    int            c;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        c   = cyc_q.pop_front();
        got = {an, seg, ready, frame_tick};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL display cyc=%0d: got an=%b seg=%b ready=%b ft=%b, expected an=%b seg=%b ready=%b ft=%b",
                   c, got[12:9], got[8:2], got[1], got[0], e[12:9], e[8:2], e[1], e[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    load     = 1'b0;
    value    = '0;
    lz_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Load 12AF at cycle 5; committed at the frame boundary (cycle 24).
    run_to(5);
    load  = 1'b1;
    value = 16'h12AF;
    tick();
    load  = 1'b0;

    // 5555 held while busy, including the commit edge: must be ignored.
    run_to(10);
    load  = 1'b1;
    value = 16'h5555;
    run_to(24);
    load  = 1'b0;

    // Accepted again once ready; leading-zero suppression on 0030.
    run_to(30);
    load  = 1'b1;
    value = 16'h0030;
    lz_en = 1'b1;
    tick();
    load  = 1'b0;

    // Value 0 with suppression: only digit 0 lights.
    run_to(60);
    load  = 1'b1;
    value = 16'h0000;
    tick();
    load  = 1'b0;

    // Leave BEEF pending, then reset while digit 0 is lit.
    run_to(96);
    load  = 1'b1;
    value = 16'hBEEF;
    tick();
    load  = 1'b0;
    tick();
    async_reset_check();

    // After release the display shows 0000 and BEEF never appears.
    run_to(30);

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
